calc_op_sequencer: RTL and testbench
====================================

# calc_op_sequencer

Multi-cycle arithmetic sequencer for the calculator. It sits between the keypad control FSM and the arithmetic datapath, and runs one operation per request. It latches operand A, operand B and the 3-bit operation code. Add and subtract finish in a fixed short latency; multiply, divide and square root run as iterative shift-based loops on a shared register set. It returns a held result with a one-cycle `done` pulse and error flags.

## Interface
- `W`, 16: operand width in bits; must be even and ≥ 4.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `abort` in 1: synchronous clear (calculator "C" key).
- `op` in 3: operation code. 000 add, 001 sub, 010 mul, 011 div, 100 sqrt; 101–111 are illegal.
- `a` in W: operand A, unsigned.
- `b` in W: operand B, unsigned; ignored for sqrt.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse; the result is valid from this cycle.
- `result` out 2W: result register, held until the next accepted `start`, `abort` or reset.
- `neg` out 1: subtract result is negative (magnitude/sign form).
- `err` out 1: divide-by-zero or illegal `op`; held with `result`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE, `start`=1:
  - Latch `a`, `b` and `op`.
  - Clear `neg`, `err` and `result`.
  - Load the iteration counter: W for mul/div, W/2 for sqrt, 0 otherwise.
  - Go to CALC.
- CALC, add: `result` = zero-extended `a+b`, including the carry into bit W.
- CALC, sub:
  - If a ≥ b: `result` = a−b, `neg`=0.
  - Otherwise: `result` = b−a, `neg`=1.
- CALC, mul: shift-add, one multiplier bit per cycle, LSB first. `result` = a·b, full 2W bits.
- CALC, div:
  - Restoring division, one quotient bit per cycle.
  - `result[W-1:0]` = quotient; `result[2W-1:W]` = remainder.
  - b=0: no iterations; `err`=1, `result`=0, go straight to FIN.
- CALC, sqrt:
  - Digit-by-digit method, two radicand bits per cycle.
  - `result[W/2-1:0]` = floor(√a); remainder bits are discarded; upper result bits are 0.
- CALC, illegal `op`: `err`=1, `result`=0, go to FIN.
- CALC → FIN when the counter reaches 0 (after the last iteration writes `result`).
- FIN: `done`=1 for this cycle only; next state is IDLE.
- `start` during CALC or FIN is ignored and is not queued.
- `abort`=1 in any state:
  - Next state is IDLE; `result`, `neg` and `err` are cleared.
  - No `done` is produced for the aborted operation.
  - `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
- Reset (`rst`=0): state IDLE; `busy`=0, `done`=0, `result`=0, `neg`=0, `err`=0. The counter and operand registers are cleared.
- Reset mid-operation takes effect immediately; no `done` is produced.

## Timing
- Count edge 0 as the edge that accepts `start`. `done` is high in the cycle after:
  - edge 1 for add, sub, div-by-zero and illegal `op`;
  - edge W for mul and div (edge 16 at W=16);
  - edge W/2 for sqrt (edge 8 at W=16).
- `busy` rises after edge 0 and falls after the edge that ends the `done` cycle.
- The earliest accepted back-to-back `start` is in the cycle after `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `calc_pkg` holds:
  - op code constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`, `OP_SQRT` (matching the 3-bit codes driven by the control FSM);
  - the state enum `seq_state_t`;
  - default `W`.
- One sub-module, `calc_iter_dp`:
  - holds the shared shift/accumulate registers and one iteration step for mul, div and sqrt;
  - is controlled by the sequencer through a `step` enable, a `load` enable and the latched op code.
- The FSM, counter and flag logic stay in `calc_op_sequencer`.

## Test plan
All scenarios use W=16.
- Mul: a=300, b=200, op=010, `start` pulse → `done` at cycle 17, `result`=60000, `err`=0, `neg`=0; `busy` high cycles 1–17.
- Div: a=100, b=7 → `result`=0x0002_000E (remainder 2, quotient 14) at cycle 17. Then a=5, b=0 → `err`=1, `result`=0, `done` at cycle 2.
- Sqrt: a=1000 → `result`=31 at cycle 9. Then a=65535 → `result`=255 at cycle 9.
- Sub: a=5, b=9 → `result`=4, `neg`=1 at cycle 2. Add: a=65535, b=1 → `result`=65536 at cycle 2. Illegal op=110 → `err`=1 at cycle 2.
- Mul 300×200 with `abort` at cycle 6 → IDLE at cycle 7, `result`=0, no `done`. A second `start` in the `done`-pending window is ignored.
- `rst` asserted low mid-div at cycle 9 → all outputs 0 immediately. After release, a fresh add 2+3 → `result`=5 at cycle 2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer: op codes,
// sequencer state encoding and the default operand width.
package calc_pkg;

   localparam int W_DEFAULT = 16;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_SQRT = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/calc_iter_dp.sv
// Shared shift/accumulate register set with one iteration step for
// shift-add multiply, restoring divide and digit-by-digit square root.
module calc_iter_dp
   import calc_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           load,
   input  logic           step,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] next_result
);

   // r_hi: partial product high half / remainder; r_lo: multiplier,
   // dividend-quotient or radicand; r_d: multiplicand, divisor or root.
   logic [W:0]   r_hi, n_hi;
   logic [W-1:0] r_lo, n_lo;
   logic [W-1:0] r_d, n_d;
   logic [W:0]   sum, shl, trial;

   always_comb begin
      n_hi        = r_hi;
      n_lo        = r_lo;
      n_d         = r_d;
      sum         = '0;
      shl         = '0;
      trial       = '0;
      next_result = '0;
      case (op)
         OP_MUL: begin
            sum          = r_hi + {1'b0, (r_lo[0] ? r_d : {W{1'b0}})};
            {n_hi, n_lo} = {1'b0, sum, r_lo[W-1:1]};
            next_result  = {n_hi[W-1:0], n_lo};
         end
         OP_DIV: begin
            shl   = {r_hi[W-1:0], r_lo[W-1]};
            trial = shl - {1'b0, r_d};
            if (shl >= {1'b0, r_d}) begin
               n_hi = trial;
               n_lo = {r_lo[W-2:0], 1'b1};
            end else begin
               n_hi = shl;
               n_lo = {r_lo[W-2:0], 1'b0};
            end
            next_result = {n_hi[W-1:0], n_lo};
         end
         OP_SQRT: begin
            // Bring down the next two radicand bits and try root*4+1.
            shl   = {r_hi[W-2:0], r_lo[W-1:W-2]};
            trial = {r_d[W-2:0], 2'b01};
            n_lo  = {r_lo[W-3:0], 2'b00};
            if (shl >= trial) begin
               n_hi = shl - trial;
               n_d  = {r_d[W-2:0], 1'b1};
            end else begin
               n_hi = shl;
               n_d  = {r_d[W-2:0], 1'b0};
            end
            next_result = {{W{1'b0}}, n_d};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi <= '0;
         r_lo <= '0;
         r_d  <= '0;
      end else if (clr) begin
         r_hi <= '0;
         r_lo <= '0;
         r_d  <= '0;
      end else if (load) begin
         r_hi <= '0;
         case (op)
            OP_MUL: begin
               r_lo <= b;
               r_d  <= a;
            end
            OP_SQRT: begin
               r_lo <= a;
               r_d  <= '0;
            end
            default: begin
               r_lo <= a;
               r_d  <= b;
            end
         endcase
      end else if (step) begin
         r_hi <= n_hi;
         r_lo <= n_lo;
         r_d  <= n_d;
      end
   end

endmodule

// File: rtl/calc_op_sequencer.sv
// Runs one arithmetic operation per start request: add/sub directly, and
// mul/div/sqrt through the iterative datapath, then pulses done.
module calc_op_sequencer
   import calc_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           neg,
   output logic           err,
   output seq_state_t     dbg_state
);

   localparam int CW = $clog2(W + 1);

   // Request protocol: start is a pulse honoured only in IDLE (never queued);
   // done is a one-cycle pulse and result/neg/err stay held until the next
   // accepted start, an abort or reset. Abort overrides start.
   seq_state_t     state;
   logic [W-1:0]   a_q, b_q;
   logic [2:0]     op_q;
   logic [CW-1:0]  cnt;
   logic           dp_load, dp_step;
   logic [2:0]     dp_op;
   logic [2*W-1:0] dp_next;

   function automatic logic [CW-1:0] iter_count(input logic [2:0] o);
      case (o)
         OP_MUL, OP_DIV: return CW'(W);
         OP_SQRT:        return CW'(W / 2);
         default:        return '0;
      endcase
   endfunction

   assign dp_load   = (state == IDLE) && start && !abort;
   assign dp_step   = (state == CALC) && !abort &&
                      ((op_q == OP_MUL) || (op_q == OP_SQRT) ||
                       ((op_q == OP_DIV) && (b_q != '0)));
   assign dp_op     = (state == IDLE) ? op : op_q;
   assign dbg_state = state;

   calc_iter_dp #(.W(W)) u_iter_dp (
      .clk         (clk),
      .rst         (rst),
      .clr         (abort),
      .load        (dp_load),
      .step        (dp_step),
      .op          (dp_op),
      .a           (a),
      .b           (b),
      .next_result (dp_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
      end else if (abort) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  op_q   <= op;
                  cnt    <= iter_count(op);
                  result <= '0;
                  neg    <= 1'b0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               case (op_q)
                  OP_ADD: begin
                     result <= {{(W-1){1'b0}}, ({1'b0, a_q} + {1'b0, b_q})};
                     done   <= 1'b1;
                     state  <= FIN;
                  end
                  OP_SUB: begin
                     if (a_q >= b_q) begin
                        result <= {{W{1'b0}}, a_q - b_q};
                     end else begin
                        result <= {{W{1'b0}}, b_q - a_q};
                        neg    <= 1'b1;
                     end
                     done  <= 1'b1;
                     state <= FIN;
                  end
                  OP_MUL, OP_DIV, OP_SQRT: begin
                     if ((op_q == OP_DIV) && (b_q == '0)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                     end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                           result <= dp_next;
                           done   <= 1'b1;
                           state  <= FIN;
                        end
                     end
                  end
                  default: begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= FIN;
                  end
               endcase
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized bench for calc_op_sequencer against an arithmetic reference model.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           neg;
  logic           err;
  seq_state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  calc_op_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .neg       (neg),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: plain arithmetic on the operation's definition
  function automatic void ref_model(input logic [2:0] o, input int unsigned av, input int unsigned bv,
                                    output logic [2*W-1:0] r, output logic n, output logic e,
                                    output int lat);
    longint unsigned x;
    r = '0; n = 1'b0; e = 1'b0; lat = 1;
    case (o)
      3'd0: r = 32'(av + bv);
      3'd1: begin
        if (av >= bv) r = 32'(av - bv);
        else begin r = 32'(bv - av); n = 1'b1; end
      end
      3'd2: begin r = 32'(av * bv); lat = W; end
      3'd3: begin
        if (bv == 0) e = 1'b1;
        else begin r = 32'(((av % bv) << W) | (av / bv)); lat = W; end
      end
      3'd4: begin
        x = 0;
        while ((x + 1) * (x + 1) <= longint'(av)) x++;
        r = 32'(x);
        lat = W / 2;
      end
      default: e = 1'b1;
    endcase
  endfunction

  // driver: caller is positioned at a falling edge
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit noise);
    logic [2*W-1:0] er, held;
    logic en, ee;
    int lat, cyc;
    ref_model(o, av, bv, er, en, ee, lat);
    exp_q.push_back(er);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check("busy_after_accept", busy, 1);
    while (!done && cyc < 40) begin
      if (noise) begin
        start = ($urandom_range(0, 2) == 0);
        a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency op%0d", o), cyc, lat);
    held = exp_q.pop_front();
    check($sformatf("result op%0d a=%0d b=%0d", o, av, bv), result, held);
    check($sformatf("neg op%0d", o), neg, en);
    check($sformatf("err op%0d", o), err, ee);
    check("busy_in_done", busy, 1);
    // a start in the done cycle must be dropped
    start = noise ? 1'b1 : 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    check("result_held", result, held);
    check("idle_after_done", dbg_state, IDLE);
  endtask

  task automatic abort_idle();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_result", result, 0);
    check("abort_neg", neg, 0);
    check("abort_err", err, 0);
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    bit saw_done;

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_neg", neg, 0);
    check("reset_err", err, 0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    run_op(3'b010, 300, 200, 0);
    run_op(3'b011, 100, 7, 0);
    run_op(3'b011, 5, 0, 0);
    run_op(3'b100, 1000, 0, 0);
    run_op(3'b100, 65535, 0, 0);
    run_op(3'b100, 0, 0, 0);
    run_op(3'b001, 5, 9, 0);
    abort_idle();
    run_op(3'b001, 7, 7, 0);
    run_op(3'b000, 65535, 1, 0);
    abort_idle();
    run_op(3'b110, 1, 2, 0);
    abort_idle();
    run_op(3'b010, 65535, 65535, 1);
    run_op(3'b011, 65535, 1, 1);

    // abort and start together: abort wins
    abort = 1'b1; start = 1'b1; op = 3'b000; a = 1; b = 1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_state", dbg_state, IDLE);

    // abort mid-multiply
    op = 3'b010; a = 300; b = 200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_mid_busy", busy, 0);
    check("abort_mid_result", result, 0);
    check("abort_mid_state", dbg_state, IDLE);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_still_idle", busy, 0);

    // asynchronous reset mid-divide
    op = 3'b011; a = 100; b = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_no_done", saw_done, 0);
    run_op(3'b000, 2, 3, 0);

    // randomized operations with ignored start noise
    repeat (60) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = '1;
        1:       ra = W'($urandom_range(0, 15));
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
